// File: rtl/writeback_pkg.sv
// writeback_pkg: shared constants, entry type and credit helper for the write-back queue.
package writeback_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int REG_COUNT = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  function automatic int free_slots(input int depth, input int count);
    return depth - count;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: dual-push, single-pop circular buffer; push0 lands ahead of push1 in order.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = writeback_pkg::wb_entry_t
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         i_push0,
  input  logic                         i_push1,
  input  entry_t                       i_entry0,
  input  entry_t                       i_entry1,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output entry_t                       o_head,
  output entry_t                       o_slot [DEPTH],
  output logic [DEPTH-1:0]             o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  entry_t r_mem [DEPTH];
  logic [PW-1:0] w_tail1, w_slot1;
  logic [1:0] w_npush;
  always_comb begin
    w_tail1 = r_tail + PW'(1);
    w_slot1 = i_push0 ? w_tail1 : r_tail;
    w_npush = {1'b0, i_push0} + {1'b0, i_push1};
  end
  // Storage carries no reset; occupancy is tracked solely by r_valid/r_count.
  always_ff @(posedge clock) begin
    if (i_push0 && !i_flush) r_mem[r_tail] <= i_entry0;
    if (i_push1 && !i_flush) r_mem[w_slot1] <= i_entry1;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head <= r_head + PW'(1);
      end
      if (i_push0) r_valid[r_tail] <= 1'b1;
      if (i_push1) r_valid[w_slot1] <= 1'b1;
      r_tail  <= r_tail + PW'(w_npush);
      r_count <= r_count + CW'(w_npush) - CW'(i_pop);
    end
  end
  assign o_head  = r_mem[r_head];
  assign o_slot  = r_mem;
  assign o_valid = r_valid;
  assign o_count = r_count;
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: arbitrates ALU/load results into an in-order FIFO and drains one
// write per cycle to the register file, exporting a per-register pending mask.
module writeback_queue
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_WIDTH-1:0]        mem_reg,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_WIDTH-1:0]        alu_reg,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         flush,
  output logic                         RegWrite,
  output logic [ADDR_WIDTH-1:0]        WriteRegister,
  output logic [DATA_WIDTH-1:0]        WriteData,
  output logic [2**ADDR_WIDTH-1:0]     pending,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  int w_free;
  logic w_mem_push, w_alu_push, w_pop;
  entry_t w_mem_entry, w_alu_entry, w_head;
  entry_t w_slot [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [2**ADDR_WIDTH-1:0] w_pending;
  logic r_we;
  logic [ADDR_WIDTH-1:0] r_wreg;
  logic [DATA_WIDTH-1:0] r_wdata;
  // Credit comes from the registered count only; a same-edge pop frees nothing.
  always_comb begin
    w_free      = free_slots(DEPTH, int'(count));
    mem_ready   = reset_n && w_free >= 1 && !flush;
    alu_ready   = reset_n && (w_free >= 2 || (w_free == 1 && !mem_valid)) && !flush;
    w_mem_push  = mem_valid && mem_ready && mem_reg != ADDR_WIDTH'(ZERO_REG);
    w_alu_push  = alu_valid && alu_ready && alu_reg != ADDR_WIDTH'(ZERO_REG);
    w_pop       = count != '0 && !flush;
    w_mem_entry = '{rd: mem_reg, data: mem_data};
    w_alu_entry = '{rd: alu_reg, data: alu_data};
  end
  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_push0  (w_mem_push),
    .i_push1  (w_alu_push),
    .i_entry0 (w_mem_entry),
    .i_entry1 (w_alu_entry),
    .i_pop    (w_pop),
    .i_flush  (flush),
    .o_head   (w_head),
    .o_slot   (w_slot),
    .o_valid  (w_valid),
    .o_count  (count)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_wreg  <= w_head.rd;
        r_wdata <= w_head.data;
      end
    end
  end
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_valid[i]) w_pending[w_slot[i].rd] = 1'b1;
    if (r_we) w_pending[r_wreg] = 1'b1;
    w_pending[0] = 1'b0;
  end
  assign pending       = w_pending;
  assign RegWrite      = r_we;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: queue-based reference model, directed scenarios and random traffic.
module tb_writeback_queue;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic mem_valid = 1'b0, alu_valid = 1'b0, flush = 1'b0;
  logic [AW-1:0] mem_reg = '0, alu_reg = '0;
  logic [DW-1:0] mem_data = '0, alu_data = '0;
  logic mem_ready, alu_ready, RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [2**AW-1:0] pending;
  logic [2:0] count;
  always #5 clock = ~clock;
  writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .flush(flush), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .pending(pending), .count(count)
  );
  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic m_rw = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  int n_tests = 0, n_fail = 0;
  logic last_mr, last_ar;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [2**AW-1:0] m_pending();
    logic [2**AW-1:0] p = '0;
    foreach (q[i]) p[q[i].r] = 1'b1;
    if (m_rw) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction
  function automatic logic m_mem_ok();
    return (DEPTH - q.size()) >= 1 && !flush;
  endfunction
  function automatic logic m_alu_ok();
    int f = DEPTH - q.size();
    return (f >= 2 || (f == 1 && !mem_valid)) && !flush;
  endfunction
  task automatic compare();
    chk("mem_ready", 64'(mem_ready), 64'(m_mem_ok()));
    chk("alu_ready", 64'(alu_ready), 64'(m_alu_ok()));
    chk("count", 64'(count), 64'(q.size()));
    chk("pending", 64'(pending), 64'(m_pending()));
    chk("RegWrite", 64'(RegWrite), 64'(m_rw));
    chk("WriteRegister", 64'(WriteRegister), 64'(m_wr));
    chk("WriteData", 64'(WriteData), 64'(m_wd));
  endtask
  task automatic step(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                      input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input logic fl);
    logic em, ea;
    @(negedge clock);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    flush = fl;
    #1;
    compare();
    last_mr = mem_ready;
    last_ar = alu_ready;
    em = m_mem_ok();
    ea = m_alu_ok();
    @(posedge clock);
    if (fl) begin
      q.delete();
      m_rw = 1'b0;
    end else begin
      m_rw = q.size() > 0;
      if (m_rw) begin
        m_wr = q[0].r;
        m_wd = q[0].d;
        void'(q.pop_front());
      end
      if (mv && em && mr != 0) q.push_back('{mr, md});
      if (av && ea && ar != 0) q.push_back('{ar, ad});
    end
    #1;
  endtask
  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask
  initial begin
    #12;
    chk("rst count", 64'(count), 64'd0);
    chk("rst RegWrite", 64'(RegWrite), 64'd0);
    chk("rst pending", 64'(pending), 64'd0);
    chk("rst readys", 64'({mem_ready, alu_ready}), 64'd0);
    chk("rst WriteRegister", 64'(WriteRegister), 64'd0);
    chk("rst WriteData", 64'(WriteData), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    // single write
    step(1'b0, '0, '0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    chk("single pending", 64'(pending), 64'h0008);
    chk("single count", 64'(count), 64'd1);
    idle();
    chk("single RegWrite", 64'(RegWrite), 64'd1);
    chk("single WriteRegister", 64'(WriteRegister), 64'd3);
    chk("single WriteData", 64'(WriteData), 64'hDEADBEEF);
    idle();
    chk("single retire RegWrite", 64'(RegWrite), 64'd0);
    chk("single retire pending", 64'(pending), 64'd0);
    // dual accept
    step(1'b1, 4'd5, 32'h11, 1'b1, 4'd6, 32'h22, 1'b0);
    chk("dual readys", 64'({last_mr, last_ar}), 64'b11);
    chk("dual count", 64'(count), 64'd2);
    idle();
    chk("dual first", 64'({WriteRegister, WriteData}), 64'({4'd5, 32'h11}));
    idle();
    chk("dual second", 64'({WriteRegister, WriteData}), 64'({4'd6, 32'h22}));
    idle();
    // fill and backpressure: pops each edge cap occupancy at DEPTH-1
    step(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102, 1'b0);
    chk("fill count1", 64'(count), 64'd2);
    step(1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104, 1'b0);
    chk("fill count2", 64'(count), 64'd3);
    chk("fill out1", 64'(WriteRegister), 64'd1);
    step(1'b1, 4'd5, 32'h105, 1'b1, 4'd6, 32'h106, 1'b0);
    chk("fill readys", 64'({last_mr, last_ar}), 64'b10);
    chk("fill out2", 64'(WriteRegister), 64'd2);
    for (int i = 3; i <= 5; i++) begin
      idle();
      chk("fill order", 64'({WriteRegister, WriteData}), 64'({4'(i), 32'h100 + 32'(i)}));
    end
    idle();
    idle();
    // zero register
    step(1'b0, '0, '0, 1'b1, 4'd0, 32'h55, 1'b0);
    chk("zero ready", 64'(last_ar), 64'd1);
    chk("zero count", 64'(count), 64'd0);
    idle();
    chk("zero RegWrite", 64'(RegWrite), 64'd0);
    chk("zero pending", 64'(pending), 64'd0);
    // flush
    step(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2, 1'b0);
    step(1'b1, 4'd4, 32'hA4, 1'b0, '0, '0, 1'b0);
    chk("pre-flush pending", 64'(pending), 64'h0016);
    step(1'b1, 4'd7, 32'hA7, 1'b1, 4'd8, 32'hA8, 1'b1);
    chk("flush readys", 64'({last_mr, last_ar}), 64'b00);
    chk("flush count", 64'(count), 64'd0);
    chk("flush RegWrite", 64'(RegWrite), 64'd0);
    chk("flush pending", 64'(pending), 64'd0);
    idle();
    chk("post-flush RegWrite", 64'(RegWrite), 64'd0);
    // async reset mid-drain
    step(1'b1, 4'd7, 32'hB7, 1'b1, 4'd8, 32'hB8, 1'b0);
    step(1'b1, 4'd9, 32'hB9, 1'b1, 4'd10, 32'hBA, 1'b0);
    chk("pre-reset state", 64'({RegWrite, count}), 64'({1'b1, 3'd3}));
    @(negedge clock);
    mem_valid = 1'b0; alu_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async RegWrite", 64'(RegWrite), 64'd0);
    chk("async count", 64'(count), 64'd0);
    chk("async pending", 64'(pending), 64'd0);
    chk("async readys", 64'({mem_ready, alu_ready}), 64'd0);
    q.delete(); m_rw = 1'b0; m_wr = '0; m_wd = '0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, '0, '0, 1'b1, 4'd3, 32'hCAFE, 1'b0);
    chk("post-reset count", 64'(count), 64'd1);
    idle();
    chk("post-reset write", 64'({RegWrite, WriteRegister, WriteData}), 64'({1'b1, 4'd3, 32'hCAFE}));
    // random traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 29) == 0);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
